sram_fb_requester: RTL and testbench
====================================

// Module: sram_fb_requester
// PURPOSE
//  Client-side master for the SRAM controller's mem/rw/ready request port.
//  Streams a frame buffer out of SRAM into a show-ahead prefetch FIFO for the
//  video output path, and services single-byte write requests from the pixel
//  writer. Sits between the NTSC video pipeline and the SRAM controller.
// PARAMETERS
//  FB_BASE    20'h00000  first frame-buffer byte address
//  FB_SIZE    20'd61440  frame-buffer length in bytes (256x240); >=1
//  FIFO_AW    3          prefetch FIFO address width; depth = 2**FIFO_AW
//  LOW_WM     2          FIFO level below which reads take priority over writes
// PORTS
//  clk          in   1        system clock (50 MHz)
//  rst_n        in   1        synchronous reset, active low
//  frame_start  in   1        1-cycle pulse: restart read stream at FB_BASE
//  fifo_rd      in   1        pop FIFO head
//  fifo_data    out  8        FIFO head byte (show-ahead)
//  fifo_empty   out  1        FIFO empty
//  fifo_count   out  FIFO_AW+1 FIFO occupancy
//  underrun     out  1        1-cycle pulse: fifo_rd while fifo_empty
//  wr_req       in   1        write request; hold with wr_addr/wr_data until wr_ack
//  wr_addr      in   20       write address
//  wr_data      in   8        write byte
//  wr_ack       out  1        1-cycle pulse: write accepted by controller
//  mem          out  1        to controller: request operation
//  rw           out  1        to controller: 1 read, 0 write
//  addr         out  20       to controller: address
//  data2ram     out  8        to controller: write byte
//  ready        in   1        from controller: idle, request sampled this cycle
//  data2fpga    in   8        from controller: registered read byte
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state S_IDLE, mem=0, rw=1, addr=FB_BASE,
//   data2ram=0, wr_ack=0, underrun=0, FIFO empty (fifo_count=0, fifo_empty=1),
//   read pointer=FB_BASE, discard flag=0. fifo_data=don't care when empty.
//  Handshake: request accepted in the cycle where mem&ready=1. Controller
//   then drops ready for exactly 2 cycles. For a read accepted in cycle T,
//   data2fpga is valid in cycle T+3 (ready=1 again).
//  mem, rw, addr, data2ram are registered; mem=1 only in S_REQ.
//  FSM:
//   S_IDLE: arbitrate; read eligible when fifo_count+inflight < 2**FIFO_AW.
//     fifo_count<LOW_WM: read first, else write first (wr_req).
//     Chosen op -> load rw/addr/data2ram, mem<=1, go S_REQ. None -> stay.
//   S_REQ: hold mem and outputs until ready=1; on acceptance mem<=0,
//     go S_WAIT; write: wr_ack=1 next cycle; read: read pointer advances.
//   S_WAIT: wait for ready=1; read: push data2fpga unless discard flag set,
//     clear discard flag; then S_IDLE. Best throughput: one op per 5 cycles.
//  Read pointer: increments per accepted read; after FB_BASE+FB_SIZE-1
//   wraps to FB_BASE (20-bit arithmetic, no carry out).
//  frame_start: FIFO flushed (count=0), read pointer=FB_BASE; if a read is in
//   S_REQ or S_WAIT, it completes on the bus but its byte is discarded.
//   An in-flight write is unaffected. frame_start wins over same-cycle push/pop.
//  FIFO: push and pop in the same cycle -> count unchanged, order preserved.
//   Pop when empty -> ignored, underrun=1 next cycle. Push never occurs full.
//  Reset mid-operation: requester returns to S_IDLE immediately. Controller
//   shares the top-level reset. Any new request still waits in S_REQ for ready.
//  inflight = 1 while a read is in S_REQ/S_WAIT, else 0.
// TESTING
//  1 Reset, idle bus, no wr_req -> reads 0x00000,0x00001,... issued until
//    fifo_count=8; data2fpga model bytes appear in order at fifo_data.
//  2 FB_SIZE=4, drain continuously -> addr sequence 0,1,2,3,0,1 (wrap).
//  3 fifo_count=5, wr_req addr=0x12345 data=0xA5 -> write issued before next
//    read; rw=0, data2ram=0xA5, wr_ack one pulse, no duplicate write.
//  4 fifo_count=1 with wr_req pending -> read issued first, then write.
//  5 frame_start during S_WAIT of read 0x00010 -> byte dropped, FIFO empty,
//    next read addr=FB_BASE.
//  6 fifo_rd on empty FIFO -> underrun pulse, fifo_count stays 0; push+pop
//    same cycle at count=3 -> count stays 3.

Source files
------------

// File: rtl/sram_fb_requester_if.sv
// -----------------------------------------------------------------------------
// sram_fb_requester_if
// Request port between a client and the SRAM controller.
//   mem        client -> controller : request an operation
//   rw         client -> controller : 1 = read, 0 = write
//   addr       client -> controller : 20-bit byte address
//   data2ram   client -> controller : write byte
//   ready      controller -> client : controller idle; request sampled this cycle
//   data2fpga  controller -> client : registered read byte
// A request is taken in the cycle where mem & ready are both high. The
// controller then holds ready low for two cycles. Read data is valid in the
// cycle where ready returns high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface sram_fb_requester_if;
   logic        mem;
   logic        rw;
   logic [19:0] addr;
   logic [7:0]  data2ram;
   logic        ready;
   logic [7:0]  data2fpga;

   modport master (
      output mem,
      output rw,
      output addr,
      output data2ram,
      input  ready,
      input  data2fpga
   );

   modport slave (
      input  mem,
      input  rw,
      input  addr,
      input  data2ram,
      output ready,
      output data2fpga
   );
endinterface

// File: rtl/sram_fb_requester.sv
// -----------------------------------------------------------------------------
// sram_fb_requester
// Client-side master on the SRAM controller request port. It streams the
// frame buffer (FB_BASE .. FB_BASE+FB_SIZE-1, wrapping) into a small
// show-ahead FIFO for the video output path and slots single-byte writes from
// the pixel writer in between the reads.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   frame_start  1-cycle pulse: flush FIFO, restart read stream at FB_BASE
//   fifo_rd      pop FIFO head
//   fifo_data    FIFO head byte (valid while fifo_empty = 0)
//   fifo_empty   FIFO empty
//   fifo_count   FIFO occupancy
//   underrun     1-cycle pulse after fifo_rd was seen on an empty FIFO
//   wr_req       write request; held with wr_addr/wr_data until wr_ack
//   wr_addr      write address
//   wr_data      write byte
//   wr_ack       1-cycle pulse: write taken by the controller
//   bus          controller request port (master side)
//
// Arbitration happens only in S_IDLE. While the FIFO is below LOW_WM the
// video stream is starving, so reads win; otherwise pending writes win.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_fb_requester #(
   parameter logic [19:0] FB_BASE = 20'h00000,
   parameter int unsigned FB_SIZE = 61440,
   parameter int unsigned FIFO_AW = 3,
   parameter int unsigned LOW_WM  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic                 fifo_rd,
   output logic [7:0]           fifo_data,
   output logic                 fifo_empty,
   output logic [FIFO_AW:0]     fifo_count,
   output logic                 underrun,
   input  logic                 wr_req,
   input  logic [19:0]          wr_addr,
   input  logic [7:0]           wr_data,
   output logic                 wr_ack,
   sram_fb_requester_if.master  bus
);

   localparam int unsigned DEPTH   = 1 << FIFO_AW;
   // Last frame-buffer address; the read pointer wraps back after it.
   localparam logic [19:0] FB_LAST = FB_BASE + 20'(FB_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t               state_q,    state_d;
   logic                 mem_q,      mem_d;
   logic                 rw_q,       rw_d;
   logic [19:0]          addr_q,     addr_d;
   logic [7:0]           data2ram_q, data2ram_d;
   logic                 wr_ack_q,   wr_ack_d;
   logic                 underrun_q, underrun_d;
   logic [19:0]          rd_ptr_q,   rd_ptr_d;
   logic                 discard_q,  discard_d;
   logic [FIFO_AW:0]     count_q,    count_d;
   logic [FIFO_AW-1:0]   head_q,     head_d;
   logic [FIFO_AW-1:0]   tail_q,     tail_d;

   logic [7:0]           fifo_mem_q [DEPTH];

   logic                 push;
   logic                 pop;
   logic                 inflight;
   logic [FIFO_AW+1:0]   level;
   logic                 read_ok;
   logic                 prefer_read;
   logic [19:0]          rd_addr_sel;

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   always_comb begin
      // A byte is pushed when the controller returns a read, unless that
      // read was started before a frame_start (discard) or frame_start is
      // flushing the FIFO in this very cycle.
      push = (state_q == S_WAIT) && bus.ready && rw_q && !discard_q && !frame_start;
      pop  = fifo_rd && (count_q != '0) && !frame_start;

      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      underrun_d = fifo_rd && (count_q == '0);

      if (frame_start) begin
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Storage carries no reset: contents are only observed while count > 0.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[tail_q] <= bus.data2fpga;
      end
   end

   // ---------------------------------------------------------------------
   // Request FSM
   // ---------------------------------------------------------------------
   always_comb begin
      // A read sitting in S_REQ/S_WAIT will still occupy a FIFO slot.
      inflight    = rw_q && (state_q != S_IDLE);
      level       = {1'b0, count_q} + {{(FIFO_AW + 1){1'b0}}, inflight};
      read_ok     = level < (FIFO_AW + 2)'(DEPTH);
      prefer_read = count_q < (FIFO_AW + 1)'(LOW_WM);
      // A read launched in the same cycle as frame_start already belongs to
      // the new frame.
      rd_addr_sel = frame_start ? FB_BASE : rd_ptr_q;

      state_d    = state_q;
      mem_d      = mem_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      data2ram_d = data2ram_q;
      wr_ack_d   = 1'b0;
      rd_ptr_d   = rd_ptr_q;
      discard_d  = discard_q;

      case (state_q)
         S_IDLE: begin
            if (read_ok && (prefer_read || !wr_req)) begin
               rw_d    = 1'b1;
               addr_d  = rd_addr_sel;
               mem_d   = 1'b1;
               state_d = S_REQ;
            end else if (wr_req) begin
               rw_d       = 1'b0;
               addr_d     = wr_addr;
               data2ram_d = wr_data;
               mem_d      = 1'b1;
               state_d    = S_REQ;
            end
         end

         S_REQ: begin
            if (bus.ready) begin
               mem_d   = 1'b0;
               state_d = S_WAIT;
               if (!rw_q) begin
                  wr_ack_d = 1'b1;
               end else begin
                  rd_ptr_d = (rd_ptr_q == FB_LAST) ? FB_BASE : rd_ptr_q + 20'd1;
               end
            end
         end

         S_WAIT: begin
            if (bus.ready) begin
               state_d = S_IDLE;
               if (rw_q) begin
                  discard_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            mem_d   = 1'b0;
         end
      endcase

      // frame_start restarts the stream. A read already on the bus must
      // finish its handshake, but its byte belongs to the old frame. When
      // that read is returning in this same cycle, the push is already
      // suppressed above, so the flag is not needed.
      if (frame_start) begin
         rd_ptr_d = FB_BASE;
         if (inflight && !((state_q == S_WAIT) && bus.ready)) begin
            discard_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mem_q      <= 1'b0;
         rw_q       <= 1'b1;
         addr_q     <= FB_BASE;
         data2ram_q <= 8'h00;
         wr_ack_q   <= 1'b0;
         underrun_q <= 1'b0;
         rd_ptr_q   <= FB_BASE;
         discard_q  <= 1'b0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         mem_q      <= mem_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         data2ram_q <= data2ram_d;
         wr_ack_q   <= wr_ack_d;
         underrun_q <= underrun_d;
         rd_ptr_q   <= rd_ptr_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.mem      = mem_q;
   assign bus.rw       = rw_q;
   assign bus.addr     = addr_q;
   assign bus.data2ram = data2ram_q;

   assign fifo_data    = fifo_mem_q[head_q];
   assign fifo_empty   = (count_q == '0);
   assign fifo_count   = count_q;
   assign underrun     = underrun_q;
   assign wr_ack       = wr_ack_q;

endmodule

// File: tb/tb_sram_fb_requester.sv
// -----------------------------------------------------------------------------
// tb_sram_fb_requester
// Two requesters: dut0 with the full frame buffer, dut1 with FB_SIZE=4 for
// the address wrap. Each has a small SRAM-controller model: takes a request on
// mem&ready, drops ready for two cycles, returns byte addr[7:0]^8'h3C with
// ready. A monitor logs every accepted request.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sram_fb_requester;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rst_n;

   // dut0 stimulus / observation
   logic        fs0, rd0, wreq0, stall0;
   logic [19:0] waddr0;
   logic [7:0]  wdata0;
   logic [7:0]  fdata0;
   logic        fempty0, und0, wack0;
   logic [3:0]  fcount0;

   // dut1 (wrap) observation
   logic        rd1;
   logic [7:0]  fdata1;
   logic        fempty1, und1, wack1;
   logic [3:0]  fcount1;

   sram_fb_requester_if bus0();
   sram_fb_requester_if bus1();

   sram_fb_requester #(.FB_BASE(20'h00000), .FB_SIZE(61440), .FIFO_AW(3), .LOW_WM(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .frame_start(fs0), .fifo_rd(rd0),
      .fifo_data(fdata0), .fifo_empty(fempty0), .fifo_count(fcount0), .underrun(und0),
      .wr_req(wreq0), .wr_addr(waddr0), .wr_data(wdata0), .wr_ack(wack0), .bus(bus0)
   );

   sram_fb_requester #(.FB_BASE(20'h00000), .FB_SIZE(4), .FIFO_AW(3), .LOW_WM(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_start(1'b0), .fifo_rd(rd1),
      .fifo_data(fdata1), .fifo_empty(fempty1), .fifo_count(fcount1), .underrun(und1),
      .wr_req(1'b0), .wr_addr(20'h00000), .wr_data(8'h00), .wr_ack(wack1), .bus(bus1)
   );

   // ---------------- controller models ----------------
   logic        rdy0_r, resp0, rdy1_r;
   logic [1:0]  cnt0, cnt1;
   logic [19:0] lat0, lat1;
   logic [7:0]  d2f0, d2f1;

   assign bus0.ready     = rdy0_r & ~stall0;
   assign bus0.data2fpga = d2f0;
   assign bus1.ready     = rdy1_r;
   assign bus1.data2fpga = d2f1;

   always @(posedge clk) begin
      if (!rst_n) begin
         rdy0_r <= 1'b1; cnt0 <= 2'd0; resp0 <= 1'b0; d2f0 <= 8'h00; lat0 <= 20'h0;
      end else begin
         resp0 <= 1'b0;
         if (bus0.mem && bus0.ready) begin
            rdy0_r <= 1'b0; cnt0 <= 2'd2; lat0 <= bus0.addr;
         end else if (cnt0 == 2'd2) begin
            cnt0 <= 2'd1;
         end else if (cnt0 == 2'd1) begin
            cnt0 <= 2'd0; rdy0_r <= 1'b1; resp0 <= 1'b1; d2f0 <= lat0[7:0] ^ 8'h3C;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         rdy1_r <= 1'b1; cnt1 <= 2'd0; d2f1 <= 8'h00; lat1 <= 20'h0;
      end else begin
         if (bus1.mem && bus1.ready) begin
            rdy1_r <= 1'b0; cnt1 <= 2'd2; lat1 <= bus1.addr;
         end else if (cnt1 == 2'd2) begin
            cnt1 <= 2'd1;
         end else if (cnt1 == 2'd1) begin
            cnt1 <= 2'd0; rdy1_r <= 1'b1; d2f1 <= lat1[7:0] ^ 8'h3C;
         end
      end
   end

   // ---------------- bus monitors ----------------
   typedef struct packed {
      logic        rw;
      logic [19:0] addr;
      logic [7:0]  wd;
   } op_t;

   op_t log0[$];
   op_t log1[$];

   always @(posedge clk) begin
      if (rst_n && bus0.mem && bus0.ready)
         log0.push_back('{rw: bus0.rw, addr: bus0.addr, wd: bus0.data2ram});
      if (rst_n && bus1.mem && bus1.ready)
         log1.push_back('{rw: bus1.rw, addr: bus1.addr, wd: bus1.data2ram});
   end

   // dut1 is drained continuously
   initial begin
      rd1 = 1'b0;
      forever begin
         @(negedge clk);
         rd1 = !fempty1;
      end
   end

   // ---------------- checking helpers ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end else begin
         $display("  ok   %-20s = 0x%0h", nm, act);
      end
   endtask

   function automatic op_t op_at(input int which, input int i);
      op_t r;
      r = '0;
      if (which == 0) begin
         if (i < log0.size()) r = log0[i];
      end else begin
         if (i < log1.size()) r = log1[i];
      end
      return r;
   endfunction

   task automatic wait_full0(input string nm);
      int n;
      n = 0;
      while (fcount0 != 4'd8 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(fcount0), 32'd8);
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_ack0(output int acks);
      acks = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (wack0) begin
            acks++;
            wreq0 = 1'b0;
         end
      end
   endtask

   task automatic chk_op(input string nm, input int idx, input logic rw,
                         input logic [19:0] addr, input logic [7:0] wd);
      op_t o;
      o = op_at(0, idx);
      chk({nm, "_rw"},   32'(o.rw),   32'(rw));
      chk({nm, "_addr"}, 32'(o.addr), 32'(addr));
      if (!rw) chk({nm, "_data"}, 32'(o.wd), 32'(wd));
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic       pop;       // input: pop after checking
      logic [7:0] exp_data;  // expected FIFO head before the pop
   } vec_t;

   vec_t        vecs [11];
   logic [19:0] wrap_exp [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      int   acks;
      int   nwr;
      logic found;

      vecs[0]  = '{1'b1, 8'h3C};
      vecs[1]  = '{1'b1, 8'h3D};
      vecs[2]  = '{1'b1, 8'h3E};
      vecs[3]  = '{1'b0, 8'h3F};
      vecs[4]  = '{1'b1, 8'h3F};
      vecs[5]  = '{1'b1, 8'h38};
      vecs[6]  = '{1'b1, 8'h39};
      vecs[7]  = '{1'b1, 8'h3A};
      vecs[8]  = '{1'b1, 8'h3B};
      vecs[9]  = '{1'b1, 8'h34};
      vecs[10] = '{1'b1, 8'h35};
      wrap_exp[0] = 20'h0; wrap_exp[1] = 20'h1; wrap_exp[2] = 20'h2;
      wrap_exp[3] = 20'h3; wrap_exp[4] = 20'h0; wrap_exp[5] = 20'h1;

      rst_n = 1'b0; fs0 = 1'b0; rd0 = 1'b0; wreq0 = 1'b0; stall0 = 1'b0;
      waddr0 = 20'h0; wdata0 = 8'h00;
      repeat (3) @(negedge clk);

      // ---- reset state ----
      chk("rst_mem",      32'(bus0.mem),      32'd0);
      chk("rst_rw",       32'(bus0.rw),       32'd1);
      chk("rst_addr",     32'(bus0.addr),     32'h0);
      chk("rst_data2ram", 32'(bus0.data2ram), 32'h0);
      chk("rst_wr_ack",   32'(wack0),         32'd0);
      chk("rst_underrun", 32'(und0),          32'd0);
      chk("rst_count",    32'(fcount0),       32'd0);
      chk("rst_empty",    32'(fempty0),       32'd1);
      rst_n = 1'b1;

      // ---- fill: reads 0..7, then stop at 8 ----
      wait_full0("fill_count");
      chk("fill_nreads", 32'(log0.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fill_rd%0d_rw", i),   32'(op_at(0, i).rw),   32'd1);
         chk($sformatf("fill_rd%0d_addr", i), 32'(op_at(0, i).addr), 32'(i));
      end
      for (int i = 0; i < 11; i++) begin
         for (int n = 0; n < 20 && fempty0; n++) @(negedge clk);
         chk($sformatf("drain_head%0d", i), 32'(fdata0), 32'(vecs[i].exp_data));
         if (vecs[i].pop) begin
            rd0 = 1'b1;
            @(negedge clk);
            rd0 = 1'b0;
         end else begin
            @(negedge clk);
         end
      end

      // ---- flush, underrun on empty FIFO ----
      wait_full0("refill_count");
      stall0 = 1'b1;
      fs0 = 1'b1;
      @(negedge clk);
      fs0 = 1'b0;
      chk("flush_count", 32'(fcount0), 32'd0);
      chk("flush_empty", 32'(fempty0), 32'd1);
      rd0 = 1'b1;
      @(negedge clk);
      rd0 = 1'b0;
      chk("underrun_pulse", 32'(und0),    32'd1);
      chk("underrun_count", 32'(fcount0), 32'd0);
      @(negedge clk);
      chk("underrun_clear", 32'(und0),    32'd0);

      // ---- push and pop in the same cycle at count 3 ----
      stall0 = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (resp0 && fcount0 == 4'd3) begin
            found = 1'b1;
            rd0 = 1'b1;
            break;
         end
      end
      @(negedge clk);
      rd0 = 1'b0;
      chk("pushpop_seen",  32'(found),   32'd1);
      chk("pushpop_count", 32'(fcount0), 32'd3);
      chk("pushpop_head",  32'(fdata0),  32'h3D);

      // ---- frame_start while read 0x00010 is in S_WAIT ----
      found = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus0.mem && bus0.ready && bus0.addr == 20'h00010) begin
            found = 1'b1;
            rd0 = 1'b0;
            break;
         end
         rd0 = !fempty0;
      end
      chk("fs_rd10_seen", 32'(found), 32'd1);
      @(negedge clk);
      fs0 = 1'b1;
      @(negedge clk);
      fs0 = 1'b0;
      chk("fs_flush_count", 32'(fcount0), 32'd0);
      repeat (2) @(negedge clk);
      chk("fs_drop_count", 32'(fcount0), 32'd0);
      chk("fs_drop_empty", 32'(fempty0), 32'd1);
      base = log0.size();
      for (int n = 0; n < 20 && log0.size() <= base; n++) @(negedge clk);
      chk_op("fs_next", base, 1'b1, 20'h00000, 8'h00);
      for (int n = 0; n < 20 && fempty0; n++) @(negedge clk);
      chk("fs_first_byte", 32'(fdata0), 32'h3C);

      // ---- count above LOW_WM: write goes before the next read ----
      wait_full0("wr_full");
      base = log0.size();
      stall0 = 1'b1;
      rd0 = 1'b1;
      repeat (3) @(negedge clk);
      rd0 = 1'b0;
      chk("wr_setup_count", 32'(fcount0), 32'd5);
      wreq0 = 1'b1; waddr0 = 20'h12345; wdata0 = 8'hA5;
      stall0 = 1'b0;
      wait_ack0(acks);
      chk("wr_ack_pulses", 32'(acks), 32'd1);
      chk_op("wr_op0", base,     1'b1, 20'h00008, 8'h00);
      chk_op("wr_op1", base + 1, 1'b0, 20'h12345, 8'hA5);
      chk_op("wr_op2", base + 2, 1'b1, 20'h00009, 8'h00);
      nwr = 0;
      for (int i = base; i < log0.size(); i++) if (!log0[i].rw) nwr++;
      chk("wr_single", 32'(nwr), 32'd1);

      // ---- count below LOW_WM: reads first, then the write ----
      wait_full0("lw_full");
      base = log0.size();
      fs0 = 1'b1;
      @(negedge clk);
      fs0 = 1'b0;
      wreq0 = 1'b1; waddr0 = 20'h00ABC; wdata0 = 8'h5E;
      wait_ack0(acks);
      chk("lw_ack_pulses", 32'(acks), 32'd1);
      chk_op("lw_op0", base,     1'b1, 20'h00000, 8'h00);
      chk_op("lw_op1", base + 1, 1'b1, 20'h00001, 8'h00);
      chk_op("lw_op2", base + 2, 1'b0, 20'h00ABC, 8'h5E);
      chk_op("lw_op3", base + 3, 1'b1, 20'h00002, 8'h00);

      // ---- FB_SIZE=4 address wrap on dut1 ----
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("wrap_rd%0d_addr", i), 32'(op_at(1, i).addr), 32'(wrap_exp[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
